// File: rtl/vc_arbiter_pkg.sv
// Shared constants for the VC-to-destination weighted round-robin arbiter.
// Holds VC indices, destination field geometry and default weights.
package vc_arbiter_pkg;

    localparam int DEST_W = 2;

    localparam int VC0 = 0;
    localparam int VC1 = 1;

    // Destination field sits in the top DEST_W bits of a word:
    // [DATA_WIDTH-DEST_HI_OFS : DATA_WIDTH-DEST_LO_OFS]
    localparam int DEST_HI_OFS = 1;
    localparam int DEST_LO_OFS = 2;

    localparam int WEIGHT_VC0_DEF = 2;
    localparam int WEIGHT_VC1_DEF = 1;

    function automatic int max_i(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vc_arbiter_if.sv
// Bundle between the VC FIFOs, the destination FIFOs and the arbiter.
// slave: arbiter view (reads flags/data, drives pops/pushes/idle).
// master: environment view (FIFOs and control FSM side).
import vc_arbiter_pkg::*;

interface vc_arbiter_if #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_VC     = 2,
    parameter int NUM_DEST   = 4
);
    logic                         enable;
    logic [NUM_VC-1:0]            vc_empty;
    logic [DEST_W*NUM_VC-1:0]     vc_head_dest;
    logic [DATA_WIDTH*NUM_VC-1:0] vc_data;
    logic [NUM_VC-1:0]            vc_pop;
    logic [NUM_DEST-1:0]          dest_almost_full;
    logic [NUM_DEST-1:0]          dest_push;
    logic [DATA_WIDTH-1:0]        dest_data;
    logic                         idle;

    modport slave (
        input  enable, vc_empty, vc_head_dest, vc_data,
        input  dest_almost_full,
        output vc_pop, dest_push, dest_data, idle
    );

    modport master (
        output enable, vc_empty, vc_head_dest, vc_data,
        output dest_almost_full,
        input  vc_pop, dest_push, dest_data, idle
    );
endinterface

// File: rtl/vc_arb_pick.sv
// Combinational eligibility and weighted round-robin pick between two VCs.
// In: enable, empties, head dests, almost-full, cur/credit. Out: grant, next state.
import vc_arbiter_pkg::*;

module vc_arb_pick #(
    parameter int NUM_VC     = 2,
    parameter int NUM_DEST   = 4,
    parameter int WEIGHT_VC0 = WEIGHT_VC0_DEF,
    parameter int WEIGHT_VC1 = WEIGHT_VC1_DEF,
    parameter int CREDIT_W   = 2
) (
    input  logic                     enable,
    input  logic [NUM_VC-1:0]        vc_empty,
    input  logic [DEST_W*NUM_VC-1:0] vc_head_dest,
    input  logic [NUM_DEST-1:0]      dest_almost_full,
    input  logic                     cur,
    input  logic [CREDIT_W-1:0]      credit,
    output logic [NUM_VC-1:0]        grant_vec,
    output logic                     next_cur,
    output logic [CREDIT_W-1:0]      next_credit
);
    localparam logic [CREDIT_W-1:0] W0  = CREDIT_W'(WEIGHT_VC0);
    localparam logic [CREDIT_W-1:0] W1  = CREDIT_W'(WEIGHT_VC1);
    localparam logic [CREDIT_W-1:0] ONE = CREDIT_W'(1);

    logic [NUM_VC-1:0]   elig;
    logic                oth;
    logic [CREDIT_W-1:0] w_cur;
    logic                quota;
    logic                stay;
    logic                swap;

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            elig[i] = enable && !vc_empty[i]
                && !dest_almost_full[vc_head_dest[DEST_W*i +: DEST_W]];
        end
    end

    always_comb begin
        oth   = ~cur;
        w_cur = cur ? W1 : W0;
        // credit 0 only exists out of reset: no run has started, so the
        // reset value of cur must not claim the first contended grant.
        quota = (credit != '0) && (credit < w_cur);
        stay  = elig[cur] && (quota || !elig[oth]);
        swap  = !stay && elig[oth];

        grant_vec   = '0;
        next_cur    = cur;
        next_credit = credit;
        unique case (1'b1)
            stay: begin
                grant_vec[cur] = 1'b1;
                next_credit    = (credit < w_cur) ? credit + ONE : ONE;
            end
            swap: begin
                grant_vec[oth] = 1'b1;
                next_cur       = oth;
                next_credit    = ONE;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/vc_arbiter.sv
// Weighted round-robin drain of two VC FIFOs into four destination FIFOs.
// Ports: clk, reset_L (async, active-low), bus (vc_arbiter_if.slave).
import vc_arbiter_pkg::*;

module vc_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_VC     = 2,
    parameter int NUM_DEST   = 4,
    parameter int WEIGHT_VC0 = WEIGHT_VC0_DEF,
    parameter int WEIGHT_VC1 = WEIGHT_VC1_DEF
) (
    input  logic        clk,
    input  logic        reset_L,
    vc_arbiter_if.slave bus
);
    localparam int CREDIT_W = $clog2(max_i(WEIGHT_VC0, WEIGHT_VC1) + 1);

    logic                  cur_q, cur_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  push_pending_q, push_pending_d;
    logic [NUM_DEST-1:0]   dest_push_q, dest_push_d;
    logic                  vc_sel_q, vc_sel_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [NUM_VC-1:0]     grant_vec;
    logic                  next_cur;
    logic [CREDIT_W-1:0]   next_credit;
    logic                  any_gnt;
    logic                  gnt_idx;
    logic [DATA_WIDTH-1:0] dest_data_c;
    logic [DEST_W-1:0]     head_dest [NUM_VC];
    logic [DATA_WIDTH-1:0] vc_word   [NUM_VC];

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            head_dest[i] = bus.vc_head_dest[DEST_W*i +: DEST_W];
            vc_word[i]   = bus.vc_data[DATA_WIDTH*i +: DATA_WIDTH];
        end
    end

    vc_arb_pick #(
        .NUM_VC     (NUM_VC),
        .NUM_DEST   (NUM_DEST),
        .WEIGHT_VC0 (WEIGHT_VC0),
        .WEIGHT_VC1 (WEIGHT_VC1),
        .CREDIT_W   (CREDIT_W)
    ) u_pick (
        .enable           (bus.enable),
        .vc_empty         (bus.vc_empty),
        .vc_head_dest     (bus.vc_head_dest),
        .dest_almost_full (bus.dest_almost_full),
        .cur              (cur_q),
        .credit           (credit_q),
        .grant_vec        (grant_vec),
        .next_cur         (next_cur),
        .next_credit      (next_credit)
    );

    assign any_gnt = |grant_vec;
    assign gnt_idx = grant_vec[VC1];

    always_comb begin
        cur_d          = next_cur;
        credit_d       = next_credit;
        push_pending_d = any_gnt;
        vc_sel_d       = any_gnt ? gnt_idx : vc_sel_q;
        dest_push_d    = '0;
        if (any_gnt) begin
            dest_push_d[head_dest[gnt_idx]] = 1'b1;
        end
        // FIFO read data arrives the cycle after the pop, so the data
        // path is a live mux during the push and a held copy otherwise.
        dest_data_c = push_pending_q ? vc_word[vc_sel_q] : data_q;
        data_d      = dest_data_c;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cur_q          <= 1'b1;
            credit_q       <= '0;
            push_pending_q <= 1'b0;
            dest_push_q    <= '0;
            vc_sel_q       <= 1'b0;
            data_q         <= '0;
        end else begin
            cur_q          <= cur_d;
            credit_q       <= credit_d;
            push_pending_q <= push_pending_d;
            dest_push_q    <= dest_push_d;
            vc_sel_q       <= vc_sel_d;
            data_q         <= data_d;
        end
    end

    assign bus.vc_pop    = grant_vec & {NUM_VC{reset_L}};
    assign bus.dest_push = dest_push_q;
    assign bus.dest_data = dest_data_c;
    assign bus.idle      = (&bus.vc_empty) && !push_pending_q;
endmodule
